// File: rtl/wb_cmd_initiator_if.sv
// wb_cmd_initiator_if: command stream, response stream and Wishbone bus of the initiator.
interface wb_cmd_initiator_if #(
    parameter int WB_ADR_WIDTH = 37,
    parameter int WB_DAT_WIDTH = 64,
    parameter int WB_SEL_WIDTH = WB_DAT_WIDTH / 8
);
    logic                    s_cmd_we;
    logic [WB_ADR_WIDTH-1:0] s_cmd_adr;
    logic [WB_DAT_WIDTH-1:0] s_cmd_dat;
    logic [WB_SEL_WIDTH-1:0] s_cmd_sel;
    logic                    s_cmd_valid;
    logic                    s_cmd_ready;
    logic [WB_DAT_WIDTH-1:0] m_rsp_dat;
    logic                    m_rsp_we;
    logic                    m_rsp_err;
    logic                    m_rsp_valid;
    logic                    m_rsp_ready;
    logic [WB_ADR_WIDTH-1:0] m_wb_adr_o;
    logic [WB_DAT_WIDTH-1:0] m_wb_dat_o;
    logic [WB_DAT_WIDTH-1:0] m_wb_dat_i;
    logic [WB_SEL_WIDTH-1:0] m_wb_sel_o;
    logic                    m_wb_we_o;
    logic                    m_wb_stb_o;
    logic                    m_wb_ack_i;
    modport master (
        input  s_cmd_we, s_cmd_adr, s_cmd_dat, s_cmd_sel, s_cmd_valid, m_rsp_ready, m_wb_dat_i, m_wb_ack_i,
        output s_cmd_ready, m_rsp_dat, m_rsp_we, m_rsp_err, m_rsp_valid,
               m_wb_adr_o, m_wb_dat_o, m_wb_sel_o, m_wb_we_o, m_wb_stb_o
    );
    modport slave (
        output s_cmd_we, s_cmd_adr, s_cmd_dat, s_cmd_sel, s_cmd_valid, m_rsp_ready, m_wb_dat_i, m_wb_ack_i,
        input  s_cmd_ready, m_rsp_dat, m_rsp_we, m_rsp_err, m_rsp_valid,
               m_wb_adr_o, m_wb_dat_o, m_wb_sel_o, m_wb_we_o, m_wb_stb_o
    );
endinterface

// File: rtl/wb_cmd_initiator.sv
// wb_cmd_initiator: Wishbone classic single-cycle initiator, one bus cycle per accepted command,
// with an ack timeout so a hung responder always yields an error response.
module wb_cmd_initiator #(
    parameter int WB_ADR_WIDTH = 37,
    parameter int WB_DAT_WIDTH = 64,
    parameter int WB_SEL_WIDTH = WB_DAT_WIDTH / 8,
    parameter int TIMEOUT      = 1024
) (
    input  logic               clk,
    input  logic               reset_n,
    wb_cmd_initiator_if.master bus,
    output logic               busy
);
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    state_t                  state_q, state_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic [WB_ADR_WIDTH-1:0] adr_q, adr_d;
    logic [WB_DAT_WIDTH-1:0] dat_q, dat_d;
    logic [WB_SEL_WIDTH-1:0] sel_q, sel_d;
    logic                    we_q, we_d;
    logic                    stb_q, stb_d;
    logic [WB_DAT_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
    logic                    rsp_we_q, rsp_we_d;
    logic                    rsp_err_q, rsp_err_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    ready;
    logic                    expire;
    assign ready  = (state_q == IDLE) && reset_n;
    assign expire = (TIMEOUT != 0) && (timer_q == TW'(TIMEOUT - 1));
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        we_d        = we_q;
        stb_d       = stb_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_we_d    = rsp_we_q;
        rsp_err_d   = rsp_err_q;
        rsp_valid_d = rsp_valid_q;
        case (state_q)
            IDLE: if (bus.s_cmd_valid && ready) begin
                adr_d   = bus.s_cmd_adr;
                dat_d   = bus.s_cmd_dat;
                sel_d   = bus.s_cmd_sel;
                we_d    = bus.s_cmd_we;
                stb_d   = 1'b1;
                timer_d = '0;
                state_d = BUS;
            end
            // ack is only honoured here, where stb is high; ack wins over a simultaneous expiry
            BUS: if (bus.m_wb_ack_i || expire) begin
                stb_d       = 1'b0;
                rsp_dat_d   = (bus.m_wb_ack_i && !we_q) ? bus.m_wb_dat_i : '0;
                rsp_err_d   = !bus.m_wb_ack_i;
                rsp_we_d    = we_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end else begin
                timer_d = (timer_q == '1) ? timer_q : timer_q + 1'b1;
            end
            RESP: if (bus.m_rsp_ready) begin
                rsp_valid_d = 1'b0;
                rsp_dat_d   = '0;
                rsp_err_d   = 1'b0;
                rsp_we_d    = 1'b0;
                adr_d       = '0;
                dat_d       = '0;
                sel_d       = '0;
                we_d        = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            we_q        <= 1'b0;
            stb_q       <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_we_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            stb_q       <= stb_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_we_q    <= rsp_we_d;
            rsp_err_q   <= rsp_err_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end
    assign bus.s_cmd_ready = ready;
    assign bus.m_wb_adr_o  = adr_q;
    assign bus.m_wb_dat_o  = dat_q;
    assign bus.m_wb_sel_o  = sel_q;
    assign bus.m_wb_we_o   = we_q;
    assign bus.m_wb_stb_o  = stb_q;
    assign bus.m_rsp_dat   = rsp_dat_q;
    assign bus.m_rsp_we    = rsp_we_q;
    assign bus.m_rsp_err   = rsp_err_q;
    assign bus.m_rsp_valid = rsp_valid_q;
    assign busy            = (state_q != IDLE);
endmodule

// File: tb/tb_wb_cmd_initiator.sv
// tb_wb_cmd_initiator: randomized transactions against a cycle-count/response model of the initiator.
module tb_wb_cmd_initiator;
    localparam int AW = 37, DW = 64, SW = 8, TO = 8;
    logic clk = 1'b0, reset_n = 1'b0, busy;
    logic ack_drv = 1'b0, b2b = 1'b0;
    logic [DW-1:0] dat_drv = '0;
    int checks = 0, errors = 0;
    always #5 clk = ~clk;
    wb_cmd_initiator_if #(.WB_ADR_WIDTH(AW), .WB_DAT_WIDTH(DW), .WB_SEL_WIDTH(SW)) bus();
    wb_cmd_initiator #(.WB_ADR_WIDTH(AW), .WB_DAT_WIDTH(DW), .WB_SEL_WIDTH(SW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus.master), .busy(busy));
    // responder: directed tests drive ack/data by hand, back-to-back mode acks every strobe from a fixed memory image
    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        return {a[31:0] ^ 32'hA5A5_5A5A, ~a[31:0]};
    endfunction
    assign bus.m_wb_ack_i = b2b ? bus.m_wb_stb_o : ack_drv;
    assign bus.m_wb_dat_i = b2b ? mem_fn(bus.m_wb_adr_o) : dat_drv;
    logic [179:0] outs;
    assign outs = {bus.m_wb_adr_o, bus.m_wb_dat_o, bus.m_wb_sel_o, bus.m_wb_we_o, bus.m_wb_stb_o, bus.m_rsp_dat,
                   bus.m_rsp_we, bus.m_rsp_err, bus.m_rsp_valid, bus.s_cmd_ready, busy};
    int cyc = 0, stb_cnt = 0, stable_cnt = 0, acc_cnt = 0, rsp_cnt = 0;
    logic [AW-1:0] mon_adr;
    logic [DW-1:0] mon_dat;
    logic [SW-1:0] mon_sel;
    logic mon_we;
    int acc_cyc[$];
    logic [DW+1:0] rsp_log[$];
    logic [AW+DW+SW-1:0] wr_log[$];
    always @(negedge clk) begin
        cyc++;
        if (bus.m_wb_stb_o) begin
            stb_cnt++;
            if (bus.m_wb_adr_o == mon_adr && bus.m_wb_dat_o == mon_dat && bus.m_wb_sel_o == mon_sel && bus.m_wb_we_o == mon_we)
                stable_cnt++;
        end
        if (bus.s_cmd_valid && bus.s_cmd_ready) begin acc_cnt++; acc_cyc.push_back(cyc); end
        if (bus.m_rsp_valid && bus.m_rsp_ready) begin rsp_cnt++; rsp_log.push_back({bus.m_rsp_we, bus.m_rsp_err, bus.m_rsp_dat}); end
        if (bus.m_wb_stb_o && bus.m_wb_ack_i && bus.m_wb_we_o) wr_log.push_back({bus.m_wb_adr_o, bus.m_wb_dat_o, bus.m_wb_sel_o});
    end
    task automatic tick; @(posedge clk); #1; endtask
    task automatic send_cmd(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat, input logic [SW-1:0] sel);
        int n = 0;
        {mon_we, mon_adr, mon_dat, mon_sel} = {we, adr, dat, sel};
        {bus.s_cmd_we, bus.s_cmd_adr, bus.s_cmd_dat, bus.s_cmd_sel} = {we, adr, dat, sel};
        bus.s_cmd_valid = 1'b1;
        while (!bus.s_cmd_ready && n < 20) begin tick(); n++; end
        if (!bus.s_cmd_ready) begin checks++; errors++; $display("FAIL cmd_accept ready=%b required=1", bus.s_cmd_ready); end
        tick();
        bus.s_cmd_valid = 1'b0;
    endtask
    // runs from the cycle after acceptance; ack is pulsed in cycle ack_delay+1 even if stb already dropped
    task automatic do_bus(input int ack_delay, output int lat);
        lat = -1;
        for (int c = 1; c < 40; c++) begin
            if (bus.m_rsp_valid && lat < 0) lat = c;
            if (lat >= 0 && c > ack_delay + 1) break;
            ack_drv = (c == ack_delay + 1);
            tick();
        end
        ack_drv = 1'b0;
    endtask
    task automatic consume;
        bus.m_rsp_ready = 1'b1; tick(); bus.m_rsp_ready = 1'b0;
    endtask
    task automatic test_reset;
        #2;
        checks++; if (outs !== '0) begin errors++; $display("FAIL reset_outs got=%h required=0", outs); end
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        checks++; if ({bus.s_cmd_ready, busy} !== 2'b10) begin errors++; $display("FAIL post_reset ready,busy=%b required=10", {bus.s_cmd_ready, busy}); end
    endtask
    task automatic test_write;
        int s0 = stb_cnt, st0 = stable_cnt, lat;
        send_cmd(1'b1, 37'h10, 64'hDEADBEEF_01234567, 8'hFF);
        checks++; if ({bus.m_wb_stb_o, busy, bus.s_cmd_ready} !== 3'b110) begin errors++; $display("FAIL wr_start stb,busy,ready=%b required=110", {bus.m_wb_stb_o, busy, bus.s_cmd_ready}); end
        do_bus(1, lat);
        checks++; if (stb_cnt - s0 != 2) begin errors++; $display("FAIL wr_stb_len got=%0d required=2", stb_cnt - s0); end
        checks++; if (stable_cnt - st0 != 2) begin errors++; $display("FAIL wr_bus_stable got=%0d required=2", stable_cnt - st0); end
        checks++; if (lat != 3) begin errors++; $display("FAIL wr_latency got=%0d required=3", lat); end
        checks++; if ({bus.m_rsp_valid, bus.m_rsp_we, bus.m_rsp_err, bus.m_rsp_dat} !== {3'b110, 64'h0})
            begin errors++; $display("FAIL wr_rsp valid,we,err=%b dat=%h required=110 dat=0", {bus.m_rsp_valid, bus.m_rsp_we, bus.m_rsp_err}, bus.m_rsp_dat); end
        consume();
        checks++; if ({busy, bus.m_rsp_valid, bus.s_cmd_ready, bus.m_wb_adr_o, bus.m_wb_dat_o, bus.m_wb_sel_o, bus.m_wb_we_o} !== {3'b001, 110'h0})
            begin errors++; $display("FAIL wr_idle_clear busy=%b adr=%h dat=%h sel=%h required cleared", busy, bus.m_wb_adr_o, bus.m_wb_dat_o, bus.m_wb_sel_o); end
    endtask
    task automatic test_read;
        int s0 = stb_cnt, st0 = stable_cnt, lat;
        dat_drv = 64'hA5A5;
        send_cmd(1'b0, 37'h20, 64'($urandom), 8'($urandom));
        do_bus(5, lat);
        checks++; if (stable_cnt - st0 != 6 || stb_cnt - s0 != 6) begin errors++; $display("FAIL rd_adr_stable stable=%0d stb=%0d required=6", stable_cnt - st0, stb_cnt - s0); end
        checks++; if (lat != 7) begin errors++; $display("FAIL rd_latency got=%0d required=7", lat); end
        checks++; if ({bus.m_rsp_valid, bus.m_rsp_we, bus.m_rsp_err, bus.m_rsp_dat} !== {3'b100, 64'hA5A5})
            begin errors++; $display("FAIL rd_rsp valid,we,err=%b dat=%h required=100 dat=a5a5", {bus.m_rsp_valid, bus.m_rsp_we, bus.m_rsp_err}, bus.m_rsp_dat); end
        consume();
    endtask
    task automatic test_timeout;
        int s0 = stb_cnt, lat;
        dat_drv = {$urandom, $urandom};
        send_cmd(1'b0, AW'($urandom), '0, 8'hF0);
        do_bus(TO, lat);
        checks++; if (stb_cnt - s0 != TO) begin errors++; $display("FAIL to_stb_len got=%0d required=%0d", stb_cnt - s0, TO); end
        checks++; if (lat != TO + 1) begin errors++; $display("FAIL to_latency got=%0d required=%0d", lat, TO + 1); end
        checks++; if ({bus.m_rsp_valid, bus.m_rsp_err, bus.m_rsp_dat, bus.m_wb_stb_o} !== {2'b11, 64'h0, 1'b0})
            begin errors++; $display("FAIL to_rsp valid,err=%b dat=%h stb=%b required=11 dat=0 stb=0", {bus.m_rsp_valid, bus.m_rsp_err}, bus.m_rsp_dat, bus.m_wb_stb_o); end
        consume();
        checks++; if ({busy, bus.m_rsp_valid} !== 2'b00) begin errors++; $display("FAIL to_idle busy,valid=%b required=00", {busy, bus.m_rsp_valid}); end
    endtask
    task automatic test_ack_at_expiry;
        int s0 = stb_cnt, lat;
        dat_drv = {$urandom, $urandom};
        send_cmd(1'b0, AW'($urandom), '0, 8'h0F);
        do_bus(TO - 1, lat);
        checks++; if ({stb_cnt - s0, lat} != {TO, TO + 1} || {bus.m_rsp_err, bus.m_rsp_dat} !== {1'b0, dat_drv})
            begin errors++; $display("FAIL ack_at_expiry stb=%0d lat=%0d err=%b dat=%h required stb=%0d lat=%0d err=0 dat=%h", stb_cnt - s0, lat, bus.m_rsp_err, bus.m_rsp_dat, TO, TO + 1, dat_drv); end
        consume();
    endtask
    task automatic test_random;
        for (int i = 0; i < 10; i++) begin
            int s0 = stb_cnt, lat, d = $urandom_range(0, 10);
            logic we = 1'($urandom);
            logic hit = (d <= TO - 1);
            int exp_stb = hit ? d + 1 : TO;
            logic [DW-1:0] exp_dat;
            dat_drv = {$urandom, $urandom};
            exp_dat = (hit && !we) ? dat_drv : '0;
            send_cmd(we, AW'({$urandom, $urandom}), {$urandom, $urandom}, 8'($urandom));
            do_bus(d, lat);
            checks++; if (stb_cnt - s0 != exp_stb || lat != exp_stb + 1 || {bus.m_rsp_we, bus.m_rsp_err, bus.m_rsp_dat} !== {we, !hit, exp_dat})
                begin errors++; $display("FAIL rand_txn%0d stb=%0d lat=%0d we,err=%b dat=%h required stb=%0d lat=%0d we,err=%b dat=%h", i, stb_cnt - s0, lat, {bus.m_rsp_we, bus.m_rsp_err}, bus.m_rsp_dat, exp_stb, exp_stb + 1, {we, !hit}, exp_dat); end
            consume();
        end
    endtask
    task automatic test_back_to_back;
        logic [AW-1:0] adr[16];
        logic [DW-1:0] dat[16];
        logic [SW-1:0] sel[16];
        logic we[16];
        int a0 = acc_cnt, r0 = rsp_cnt, w0 = wr_log.size(), ai = acc_cyc.size(), ri = rsp_log.size(), n = 0, wi;
        for (int i = 0; i < 16; i++) begin
            adr[i] = AW'({$urandom, $urandom}); dat[i] = {$urandom, $urandom}; sel[i] = 8'($urandom); we[i] = 1'($urandom);
        end
        b2b = 1'b1; bus.m_rsp_ready = 1'b1;
        while (acc_cnt - a0 < 16 && n < 200) begin
            {bus.s_cmd_we, bus.s_cmd_adr, bus.s_cmd_dat, bus.s_cmd_sel} = {we[acc_cnt - a0], adr[acc_cnt - a0], dat[acc_cnt - a0], sel[acc_cnt - a0]};
            bus.s_cmd_valid = 1'b1;
            tick(); n++;
        end
        bus.s_cmd_valid = 1'b0;
        n = 0;
        while (rsp_cnt - r0 < 16 && n < 50) begin tick(); n++; end
        checks++; if (rsp_cnt - r0 != 16 || acc_cnt - a0 != 16) begin errors++; $display("FAIL b2b_count acc=%0d rsp=%0d required=16", acc_cnt - a0, rsp_cnt - r0); end
        for (int i = 1; i < 16 && ai + i < acc_cyc.size(); i++) begin
            checks++; if (acc_cyc[ai + i] - acc_cyc[ai + i - 1] != 3) begin errors++; $display("FAIL b2b_period%0d got=%0d required=3", i, acc_cyc[ai + i] - acc_cyc[ai + i - 1]); end
        end
        wi = w0;
        for (int i = 0; i < 16 && ri + i < rsp_log.size(); i++) begin
            logic [DW+1:0] exp = {we[i], 1'b0, we[i] ? 64'h0 : mem_fn(adr[i])};
            checks++; if (rsp_log[ri + i] !== exp) begin errors++; $display("FAIL b2b_rsp%0d got=%h required=%h", i, rsp_log[ri + i], exp); end
            if (we[i]) begin
                checks++; if (wi >= wr_log.size() || wr_log[wi] !== {adr[i], dat[i], sel[i]})
                    begin errors++; $display("FAIL b2b_wr%0d got=%h required=%h", i, (wi < wr_log.size()) ? wr_log[wi] : '0, {adr[i], dat[i], sel[i]}); end
                wi++;
            end
        end
        b2b = 1'b0; bus.m_rsp_ready = 1'b0;
    endtask
    task automatic test_stall;
        int lat;
        logic [DW-1:0] exp;
        dat_drv = {$urandom, $urandom}; exp = dat_drv;
        send_cmd(1'b0, AW'($urandom), '0, 8'hFF);
        do_bus(0, lat);
        dat_drv = ~dat_drv;
        for (int i = 0; i < 10; i++) begin
            checks++; if ({bus.m_rsp_valid, bus.s_cmd_ready, bus.m_wb_stb_o, busy, bus.m_rsp_dat} !== {4'b1001, exp})
                begin errors++; $display("FAIL stall%0d valid,ready,stb,busy=%b dat=%h required=1001 dat=%h", i, {bus.m_rsp_valid, bus.s_cmd_ready, bus.m_wb_stb_o, busy}, bus.m_rsp_dat, exp); end
            tick();
        end
        consume();
    endtask
    task automatic test_reset_mid_bus;
        int r0;
        send_cmd(1'b1, AW'($urandom), {$urandom, $urandom}, 8'hAA);
        tick();
        checks++; if (bus.m_wb_stb_o !== 1'b1) begin errors++; $display("FAIL mid_bus_stb got=%b required=1", bus.m_wb_stb_o); end
        reset_n = 1'b0;
        #1;
        checks++; if (outs !== '0) begin errors++; $display("FAIL mid_bus_reset_outs got=%h required=0", outs); end
        tick(); tick();
        reset_n = 1'b1;
        r0 = rsp_cnt;
        bus.m_rsp_ready = 1'b1;
        repeat (12) tick();
        bus.m_rsp_ready = 1'b0;
        checks++; if (rsp_cnt != r0 || {busy, bus.m_rsp_valid, bus.s_cmd_ready, bus.m_wb_stb_o} !== 4'b0010)
            begin errors++; $display("FAIL post_abort rsp=%0d busy,valid,ready,stb=%b required rsp=0 0010", rsp_cnt - r0, {busy, bus.m_rsp_valid, bus.s_cmd_ready, bus.m_wb_stb_o}); end
    endtask
    initial begin
        bus.s_cmd_valid = 1'b0; bus.s_cmd_we = 1'b0; bus.s_cmd_adr = '0; bus.s_cmd_dat = '0; bus.s_cmd_sel = '0;
        bus.m_rsp_ready = 1'b0;
        mon_adr = '0; mon_dat = '0; mon_sel = '0; mon_we = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_ack_at_expiry();
        test_random();
        test_back_to_back();
        test_stall();
        test_reset_mid_bus();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
